// File: rtl/frame_seq_if.sv
// Handshake bundle between the frame sequencer and its rasterizer, colorloops,
// clip/split front end and display.
interface frame_seq_if #(
    parameter int NUM_CF_MODS = 4,
    parameter int FRAME_CNT_W = 16
);
    logic                   abort;
    logic                   tri_valid;
    logic                   tri_last;
    logic                   tri_ready;
    logic                   raster_start;
    logic                   raster_done;
    logic                   wf_flip;
    logic [NUM_CF_MODS-1:0] cl_start;
    logic [NUM_CF_MODS-1:0] cl_done;
    logic                   disp_idle;
    logic                   fb_flip;
    logic [FRAME_CNT_W-1:0] frame_count;
    logic                   busy;

    modport master (
        output abort, tri_valid, tri_last, raster_done, cl_done, disp_idle,
        input  tri_ready, raster_start, wf_flip, cl_start, fb_flip, frame_count, busy
    );

    modport slave (
        input  abort, tri_valid, tri_last, raster_done, cl_done, disp_idle,
        output tri_ready, raster_start, wf_flip, cl_start, fb_flip, frame_count, busy
    );
endinterface

// File: rtl/frame_sequencer.sv
// Schedules the double-buffered wireframe and frame-buffer SRAMs: front FSM feeds the
// rasterizer triangle by triangle, back FSM colours the flipped wireframe and flips to display.
//
// state   | meaning
// R_IDLE  | ready for next triangle
// R_START | pulse raster_start for captured triangle
// R_WAIT  | rasterizer busy
// R_HOLD  | frame rasterized, waiting for wireframe swap
// C_IDLE  | colorloops free
// C_START | colorloops launched next cycle, done mask cleared
// C_RUN   | collecting per-slice done pulses
// C_HOLD  | frame buffer complete, waiting for display
module frame_sequencer #(
    parameter int NUM_CF_MODS = 4,
    parameter int FRAME_CNT_W = 16
) (
    input  logic       clk,
    input  logic       n_rst,
    frame_seq_if.slave bus
);
    typedef enum logic [1:0] {R_IDLE, R_START, R_WAIT, R_HOLD} front_t;
    typedef enum logic [1:0] {C_IDLE, C_START, C_RUN, C_HOLD} back_t;

    localparam logic [NUM_CF_MODS-1:0] ALL_DONE = '1;

    front_t                 front, front_nxt;
    back_t                  back, back_nxt;
    logic                   last_q, last_nxt;
    logic [NUM_CF_MODS-1:0] done_mask, mask_nxt;
    logic                   wf_swap, fb_swap;
    logic                   raster_start_q, wf_flip_q, fb_flip_q;
    logic [NUM_CF_MODS-1:0] cl_start_q;
    logic [FRAME_CNT_W-1:0] frame_count_q;

    always_comb begin
        front_nxt = front;
        back_nxt  = back;
        last_nxt  = last_q;
        mask_nxt  = done_mask;
        wf_swap   = (front == R_HOLD) && (back == C_IDLE);
        fb_swap   = (back == C_HOLD) && bus.disp_idle;

        case (front)
            R_IDLE: begin
                if (bus.tri_valid) begin
                    last_nxt  = bus.tri_last;
                    front_nxt = R_START;
                end
            end
            R_START: front_nxt = R_WAIT;
            R_WAIT: begin
                if (bus.raster_done) front_nxt = last_q ? R_HOLD : R_IDLE;
            end
            R_HOLD: begin
                if (back == C_IDLE) front_nxt = R_IDLE;
            end
            default: front_nxt = R_IDLE;
        endcase

        case (back)
            C_IDLE: begin
                if (wf_swap) back_nxt = C_START;
            end
            C_START: begin
                mask_nxt = '0;
                back_nxt = C_RUN;
            end
            C_RUN: begin
                mask_nxt = done_mask | bus.cl_done;
                if (mask_nxt == ALL_DONE) back_nxt = C_HOLD;
            end
            C_HOLD: begin
                if (bus.disp_idle) back_nxt = C_IDLE;
            end
            default: back_nxt = C_IDLE;
        endcase

        // abort overrides every transition and suppresses all pulses
        if (bus.abort) begin
            front_nxt = R_IDLE;
            back_nxt  = C_IDLE;
            last_nxt  = 1'b0;
            mask_nxt  = '0;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            front          <= R_IDLE;
            back           <= C_IDLE;
            last_q         <= 1'b0;
            done_mask      <= '0;
            raster_start_q <= 1'b0;
            wf_flip_q      <= 1'b0;
            cl_start_q     <= '0;
            fb_flip_q      <= 1'b0;
            frame_count_q  <= '0;
        end else begin
            front          <= front_nxt;
            back           <= back_nxt;
            last_q         <= last_nxt;
            done_mask      <= mask_nxt;
            raster_start_q <= (front_nxt == R_START);
            wf_flip_q      <= wf_swap && !bus.abort;
            cl_start_q     <= ((back == C_START) && !bus.abort) ? ALL_DONE : '0;
            fb_flip_q      <= fb_swap && !bus.abort;
            if (fb_swap && !bus.abort) frame_count_q <= frame_count_q + FRAME_CNT_W'(1);
        end
    end

    assign bus.tri_ready    = (front == R_IDLE);
    assign bus.busy         = (front != R_IDLE) || (back != C_IDLE);
    assign bus.raster_start = raster_start_q;
    assign bus.wf_flip      = wf_flip_q;
    assign bus.cl_start     = cl_start_q;
    assign bus.fb_flip      = fb_flip_q;
    assign bus.frame_count  = frame_count_q;
endmodule

// File: tb/tb_frame_sequencer.sv
// Randomized bench for frame_sequencer: a timestamp-based frame model predicts every
// pulse, tri_ready, busy and frame_count cycle by cycle.
module tb_frame_sequencer;
    localparam int NCF = 4;
    localparam int FCW = 2;
    localparam int SW  = 5 + NCF + FCW;
    localparam int INF = 1 << 30;

    logic clk = 1'b0;
    logic n_rst = 1'b0;

    frame_seq_if #(.NUM_CF_MODS(NCF), .FRAME_CNT_W(FCW)) bus ();

    frame_sequencer #(.NUM_CF_MODS(NCF), .FRAME_CNT_W(FCW)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_count = 0;

    // {tri_ready, busy, raster_start, wf_flip, fb_flip, cl_start, frame_count}
    wire [SW-1:0] snap = {bus.tri_ready, bus.busy, bus.raster_start, bus.wf_flip,
                          bus.fb_flip, bus.cl_start, bus.frame_count};

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic quiet_inputs();
        bus.abort       = 1'b0;
        bus.tri_valid   = 1'b0;
        bus.tri_last    = 1'b0;
        bus.raster_done = 1'b0;
        bus.cl_done     = '0;
        bus.disp_idle   = 1'b0;
    endtask

    // Frame model: every event is a cycle timestamp derived from the sequencing rules.
    task automatic run_frames(input int nframes, input int idle_pct);
        int k, budget, frames_left, tris_left, flipped, c, maxr;
        int acc_t, done_t, ready_at, hold_since, idle_since;
        int bi_from, bi_to, wf_t, cl_t, e_t, chold_at, fb_t;
        int r[NCF];
        bit in_flight, cur_last, exp_ready, exp_busy;
        logic [NCF-1:0] cd;
        logic [SW-1:0] exp_snap;
        k = 0; budget = 300 * nframes + 50;
        frames_left = nframes; tris_left = int'($urandom_range(4, 1)); flipped = 0;
        acc_t = -10; done_t = -10; ready_at = 0; hold_since = -1; idle_since = 0;
        bi_from = 0; bi_to = INF; wf_t = -10; cl_t = -10; e_t = -10; chold_at = -1; fb_t = -10;
        in_flight = 0; cur_last = 0;
        for (int i = 0; i < NCF; i++) r[i] = 0;
        while (!(flipped == nframes && k > fb_t + 1)) begin
            if (k > budget) begin
                n_tests++; n_fail++;
                $display("FAIL run_frames_timeout: delivered %0d frames, required %0d", flipped, nframes);
                break;
            end
            if (k == fb_t) exp_count = (exp_count + 1) % (1 << FCW);
            exp_ready = (k >= ready_at);
            exp_busy  = !exp_ready || !(k >= bi_from && k <= bi_to);
            exp_snap  = {exp_ready, exp_busy, acc_t == k - 1, wf_t == k, fb_t == k,
                         (cl_t == k) ? {NCF{1'b1}} : {NCF{1'b0}}, FCW'(exp_count)};
            n_tests++;
            if (snap !== exp_snap) begin
                n_fail++;
                $display("FAIL frame_cycle k=%0d: got %b, expected %b (ready,busy,rs,wf,fb,cl,cnt)",
                         k, snap, exp_snap);
            end

            bus.raster_done = 1'b0;
            if (k == done_t) begin
                bus.raster_done = 1'b1;
                in_flight = 0;
                if (cur_last) hold_since = k + 1;
                else ready_at = k + 1;
            end else if (!in_flight) begin
                bus.raster_done = ($urandom_range(9, 0) == 0);
            end

            cd = '0;
            if (k >= cl_t && k <= e_t) begin
                for (int i = 0; i < NCF; i++) begin
                    if (cl_t + r[i] == k) cd[i] = 1'b1;
                    else if (cl_t + r[i] < k && $urandom_range(2, 0) == 0) cd[i] = 1'b1;
                end
            end else if ($urandom_range(7, 0) == 0) begin
                cd = NCF'($urandom);
            end
            bus.cl_done = cd;

            bus.disp_idle = (int'($urandom_range(99, 0)) < idle_pct);
            if (chold_at >= 0 && k >= chold_at && bus.disp_idle) begin
                fb_t = k + 1; idle_since = k + 1; bi_from = k + 1; bi_to = INF;
                chold_at = -1; flipped++;
            end

            if (hold_since >= 0 && idle_since >= 0) begin
                c = (hold_since > idle_since) ? hold_since : idle_since;
                wf_t = c + 1; cl_t = c + 2; ready_at = c + 1; bi_to = c;
                hold_since = -1; idle_since = -1; maxr = 0;
                for (int i = 0; i < NCF; i++) begin
                    r[i] = int'($urandom_range(5, 0));
                    if (r[i] > maxr) maxr = r[i];
                end
                e_t = cl_t + maxr; chold_at = e_t + 1;
            end

            bus.tri_valid = 1'b0;
            bus.tri_last  = 1'($urandom);
            if (frames_left > 0 && $urandom_range(9, 0) < 6) begin
                bus.tri_valid = 1'b1;
                bus.tri_last  = (tris_left == 1);
                if (k >= ready_at) begin
                    acc_t = k; in_flight = 1; ready_at = INF; cur_last = bus.tri_last;
                    done_t = k + 1 + int'($urandom_range(3, 1));
                    tris_left--;
                    if (tris_left == 0) begin
                        frames_left--;
                        tris_left = int'($urandom_range(4, 1));
                    end
                end
            end
            tick();
            k++;
        end
        quiet_inputs();
    endtask

    task automatic test_reset();
        quiet_inputs();
        n_rst = 1'b0;
        repeat (2) tick();
        n_tests++;
        if (snap !== {1'b1, 1'b0, 3'b000, {NCF{1'b0}}, {FCW{1'b0}}}) begin
            n_fail++;
            $display("FAIL reset_values: got %b, expected tri_ready=1 and all else 0", snap);
        end
        #2 n_rst = 1'b1;
        tick();
        n_tests++;
        if (snap !== {1'b1, 1'b0, 3'b000, {NCF{1'b0}}, {FCW{1'b0}}}) begin
            n_fail++;
            $display("FAIL after_reset_idle: got %b, expected tri_ready=1 and all else 0", snap);
        end
        exp_count = 0;
    endtask

    task automatic test_frames();
        run_frames(2, 60);
        run_frames(6, 50);
    endtask

    task automatic test_backpressure();
        run_frames(3, 5);
    endtask

    task automatic test_stray();
        logic [SW-1:0] idle_snap;
        idle_snap = {1'b1, 1'b0, 3'b000, {NCF{1'b0}}, FCW'(exp_count)};
        for (int i = 0; i < 12; i++) begin
            bus.tri_valid   = 1'b0;
            bus.tri_last    = 1'($urandom);
            bus.raster_done = 1'($urandom);
            bus.cl_done     = NCF'($urandom);
            bus.disp_idle   = 1'($urandom);
            tick();
            n_tests++;
            if (snap !== idle_snap) begin
                n_fail++;
                $display("FAIL stray_inputs cycle %0d: got %b, expected %b", i, snap, idle_snap);
            end
        end
        quiet_inputs();
        tick();
        run_frames(1, 50);
    endtask

    // Launches a one-triangle frame and returns with the back FSM in C_RUN.
    task automatic start_single_frame(input string tag);
        logic [FCW-1:0] cnt;
        cnt = FCW'(exp_count);
        quiet_inputs();
        bus.tri_valid = 1'b1; bus.tri_last = 1'b1;
        tick();
        bus.tri_valid = 1'b0; bus.tri_last = 1'b0;
        tick();
        bus.raster_done = 1'b1;
        tick();
        bus.raster_done = 1'b0;
        tick();
        n_tests++;
        if (snap !== {1'b1, 1'b1, 1'b0, 1'b1, 1'b0, {NCF{1'b0}}, cnt}) begin
            n_fail++;
            $display("FAIL %s_wf_flip: got %b, expected wf_flip with tri_ready=1 busy=1", tag, snap);
        end
        tick();
        n_tests++;
        if (snap !== {1'b1, 1'b1, 3'b000, {NCF{1'b1}}, cnt}) begin
            n_fail++;
            $display("FAIL %s_cl_start: got %b, expected cl_start all ones one cycle after wf_flip", tag, snap);
        end
    endtask

    task automatic test_abort();
        logic [SW-1:0] idle_snap;
        idle_snap = {1'b1, 1'b0, 3'b000, {NCF{1'b0}}, FCW'(exp_count)};
        quiet_inputs();
        bus.tri_valid = 1'b1; bus.tri_last = 1'b0;
        tick();
        bus.tri_valid = 1'b0;
        n_tests++;
        if (snap !== {1'b0, 1'b1, 1'b1, 2'b00, {NCF{1'b0}}, FCW'(exp_count)}) begin
            n_fail++;
            $display("FAIL abort_setup_raster_start: got %b, expected raster_start=1 tri_ready=0", snap);
        end
        tick();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0; bus.raster_done = 1'b1;
        n_tests++;
        if (snap !== idle_snap) begin
            n_fail++;
            $display("FAIL abort_in_r_wait: got %b, expected %b", snap, idle_snap);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            bus.raster_done = 1'b0;
            n_tests++;
            if (snap !== idle_snap) begin
                n_fail++;
                $display("FAIL abort_r_wait_quiet cycle %0d: got %b, expected %b", i, snap, idle_snap);
            end
        end

        start_single_frame("abort");
        bus.cl_done = 4'b0101;
        tick();
        bus.cl_done = '0; bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0; bus.cl_done = 4'b1010; bus.disp_idle = 1'b1;
        n_tests++;
        if (snap !== idle_snap) begin
            n_fail++;
            $display("FAIL abort_in_c_run: got %b, expected %b", snap, idle_snap);
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            bus.cl_done = '0;
            n_tests++;
            if (snap !== idle_snap) begin
                n_fail++;
                $display("FAIL abort_c_run_quiet cycle %0d: got %b, expected %b", i, snap, idle_snap);
            end
        end
        quiet_inputs();
        tick();
        run_frames(1, 50);
    endtask

    task automatic test_async_reset();
        logic [SW-1:0] rst_snap;
        rst_snap = {1'b1, 1'b0, 3'b000, {NCF{1'b0}}, {FCW{1'b0}}};
        start_single_frame("async_rst");
        bus.cl_done = 4'b0011;
        tick();
        bus.cl_done = 4'b1100; bus.disp_idle = 1'b1;
        #2 n_rst = 1'b0;
        #1;
        exp_count = 0;
        n_tests++;
        if (snap !== rst_snap) begin
            n_fail++;
            $display("FAIL async_reset_immediate: got %b, expected %b", snap, rst_snap);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++;
            if (snap !== rst_snap) begin
                n_fail++;
                $display("FAIL async_reset_held cycle %0d: got %b, expected %b", i, snap, rst_snap);
            end
        end
        quiet_inputs();
        #2 n_rst = 1'b1;
        tick();
        n_tests++;
        if (snap !== rst_snap) begin
            n_fail++;
            $display("FAIL async_reset_release: got %b, expected %b", snap, rst_snap);
        end
        run_frames(2, 50);
    endtask

    initial begin
        quiet_inputs();
        test_reset();
        test_frames();
        test_backpressure();
        test_stray();
        test_abort();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
